// File: rtl/ft_miss_handler.sv
// ft_miss_handler
//   Queues forwarding-table misses and sends them to the SDN controller one
//   at a time. Each matching controller reply is written back into the
//   forwarding table.
//
// Ports
//   clk, rst               : clock, synchronous active-high reset
//   miss_*                 : one-cycle miss pulse and header fields from the table
//   o_ctrl_req_valid/_data : request to the controller (valid/ready handshake)
//   i_ctrl_req_ready       : controller accepts the request
//   i_ctrl_resp_valid/_data: controller reply (new table entry)
//   wr_valid/wr_data       : table write port
//   o_busy                 : FIFO non-empty or FSM not idle
//   o_drop_cnt             : saturating count of dropped misses
//   o_timeout_cnt          : saturating count of reply timeouts
//
// Build option
//   FT_MISS_DEDUP_EN : when defined, a miss is dropped if its dest_mac is
//                      already queued or currently in flight.
//
// Entry layout (MSB first): dest_mac[167:120] src_mac[119:72]
//   dest_ip[71:40] src_ip[39:8] port[7:0]
module ft_miss_handler #(
   parameter int NUM_INTERFACES = 3,
   parameter int ENTRY_WIDTH    = 168,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IFW           = $clog2(NUM_INTERFACES)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   miss_valid,
   input  logic [47:0]            miss_dest_mac,
   input  logic [47:0]            miss_src_mac,
   input  logic [31:0]            miss_dest_ip,
   input  logic [31:0]            miss_src_ip,
   input  logic [IFW-1:0]         miss_ifc,
   output logic                   o_ctrl_req_valid,
   input  logic                   i_ctrl_req_ready,
   output logic [ENTRY_WIDTH-1:0] o_ctrl_req_data,
   input  logic                   i_ctrl_resp_valid,
   input  logic [ENTRY_WIDTH-1:0] i_ctrl_resp_data,
   output logic                   wr_valid,
   output logic [ENTRY_WIDTH-1:0] wr_data,
   output logic                   o_busy,
   output logic [15:0]            o_drop_cnt,
   output logic [15:0]            o_timeout_cnt
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int TW  = $clog2(TIMEOUT_CYCLES);
   localparam int MSB = ENTRY_WIDTH - 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE} state_t;

   logic [ENTRY_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   state_t                 state_q, state_d;
   logic [ENTRY_WIDTH-1:0] inflight_q, inflight_d;
   logic [ENTRY_WIDTH-1:0] resp_q, resp_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic [15:0]            drop_q, drop_d, tocnt_q, tocnt_d;

   logic [ENTRY_WIDTH-1:0] req_packed;
   logic                   fifo_full, fifo_empty, dup_hit, push, pop, resp_match;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign req_packed = {miss_dest_mac, miss_src_mac, miss_dest_ip, miss_src_ip,
                        {(8-IFW){1'b0}}, miss_ifc};
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign resp_match = (i_ctrl_resp_data[MSB -: 48] == inflight_q[MSB -: 48]);

`ifdef FT_MISS_DEDUP_EN
   // Compare against every occupied slot (head + i for i < count) and the
   // in-flight request once it has left IDLE.
   always_comb begin
      dup_hit = 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         if ((CW'(i) < count_q) &&
             (fifo_mem_q[rd_ptr_q + AW'(i)][MSB -: 48] == miss_dest_mac))
            dup_hit = 1'b1;
      end
      if ((state_q != S_IDLE) && (inflight_q[MSB -: 48] == miss_dest_mac))
         dup_hit = 1'b1;
   end
`else
   assign dup_hit = 1'b0;
`endif

   // Fullness uses the current count, so a push while full is dropped even
   // when the FSM pops in the same cycle.
   always_comb begin
      push     = miss_valid && !fifo_full && !dup_hit;
      drop_d   = (miss_valid && !push) ? sat_inc(drop_q) : drop_q;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_comb begin
      state_d    = state_q;
      inflight_d = inflight_q;
      resp_d     = resp_q;
      tmo_d      = tmo_q;
      tocnt_d    = tocnt_q;
      pop        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               inflight_d = fifo_mem_q[rd_ptr_q];
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (i_ctrl_req_ready) begin
               state_d = S_WAIT;
               tmo_d   = '0;
            end
         end
         S_WAIT: begin
            tmo_d = tmo_q + TW'(1);
            // A matching reply in the final cycle takes priority over timeout.
            if (i_ctrl_resp_valid && resp_match) begin
               resp_d  = i_ctrl_resp_data;
               state_d = S_WRITE;
            end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
               state_d = S_IDLE;
               tocnt_d = sat_inc(tocnt_q);
            end
         end
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         inflight_q <= '0;
         resp_q     <= '0;
         tmo_q      <= '0;
         drop_q     <= '0;
         tocnt_q    <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         resp_q     <= resp_d;
         tmo_q      <= tmo_d;
         drop_q     <= drop_d;
         tocnt_q    <= tocnt_d;
      end
   end

   // Queue storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= req_packed;
   end

   assign o_ctrl_req_valid = (state_q == S_REQ);
   assign o_ctrl_req_data  = inflight_q;
   assign wr_valid         = (state_q == S_WRITE);
   assign wr_data          = resp_q;
   assign o_busy           = !fifo_empty || (state_q != S_IDLE);
   assign o_drop_cnt       = drop_q;
   assign o_timeout_cnt    = tocnt_q;

endmodule

// File: tb/tb_ft_miss_handler.sv
module tb_ft_miss_handler;

   localparam int EW = 168;

   logic          clk = 1'b0;
   logic          rst;
   logic          miss_valid;
   logic [47:0]   miss_dest_mac, miss_src_mac;
   logic [31:0]   miss_dest_ip, miss_src_ip;
   logic [1:0]    miss_ifc;
   logic          o_ctrl_req_valid, i_ctrl_req_ready;
   logic [EW-1:0] o_ctrl_req_data;
   logic          i_ctrl_resp_valid;
   logic [EW-1:0] i_ctrl_resp_data;
   logic          wr_valid;
   logic [EW-1:0] wr_data;
   logic          o_busy;
   logic [15:0]   o_drop_cnt, o_timeout_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   ft_miss_handler #(
      .NUM_INTERFACES(3), .ENTRY_WIDTH(EW), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst),
      .miss_valid(miss_valid), .miss_dest_mac(miss_dest_mac), .miss_src_mac(miss_src_mac),
      .miss_dest_ip(miss_dest_ip), .miss_src_ip(miss_src_ip), .miss_ifc(miss_ifc),
      .o_ctrl_req_valid(o_ctrl_req_valid), .i_ctrl_req_ready(i_ctrl_req_ready),
      .o_ctrl_req_data(o_ctrl_req_data),
      .i_ctrl_resp_valid(i_ctrl_resp_valid), .i_ctrl_resp_data(i_ctrl_resp_data),
      .wr_valid(wr_valid), .wr_data(wr_data), .o_busy(o_busy),
      .o_drop_cnt(o_drop_cnt), .o_timeout_cnt(o_timeout_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got running required done");
      $fatal(1, "watchdog");
   end

   // Stimulus derivation from a dest MAC
   function automatic logic [1:0] ifc_of(input logic [47:0] mac);
      return mac[0] ? 2'd1 : 2'd2;
   endfunction
   function automatic logic [47:0] smac_of(input logic [47:0] mac);
      return mac ^ 48'hAA00_0000_0000;
   endfunction
   function automatic logic [31:0] dip_of(input logic [47:0] mac);
      return 32'h0A00_0000 + mac[31:0];
   endfunction
   function automatic logic [31:0] sip_of(input logic [47:0] mac);
      return 32'hC0A8_0000 + {16'h0, mac[15:0]};
   endfunction
   function automatic logic [EW-1:0] exp_req(input logic [47:0] mac);
      return {mac, smac_of(mac), dip_of(mac), sip_of(mac), 6'd0, ifc_of(mac)};
   endfunction
   function automatic logic [EW-1:0] resp_of(input logic [47:0] mac);
      return {mac, 48'h0011_2233_4455 ^ mac, 32'hDEAD_0000 | {16'h0, mac[15:0]},
              32'h1234_5678, 8'h02};
   endfunction

   task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h required %h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_miss(input logic [47:0] mac);
      miss_valid    = 1'b1;
      miss_dest_mac = mac;
      miss_src_mac  = smac_of(mac);
      miss_dest_ip  = dip_of(mac);
      miss_src_ip   = sip_of(mac);
      miss_ifc      = ifc_of(mac);
   endtask

   task automatic send_miss(input logic [47:0] mac);
      set_miss(mac);
      step();
      miss_valid = 1'b0;
   endtask

   // Wait (bounded) for a request, check it, accept it; returns in WAIT cycle 1.
   task automatic to_wait(input string tag, input logic [47:0] mac);
      int n = 0;
      while (!o_ctrl_req_valid && n < 30) begin
         step();
         n++;
      end
      check({tag, "_req_valid"}, EW'(o_ctrl_req_valid), EW'(1));
      check({tag, "_req_data"}, o_ctrl_req_data, exp_req(mac));
      i_ctrl_req_ready = 1'b1;
      step();
      i_ctrl_req_ready = 1'b0;
   endtask

   task automatic txn(input string tag, input logic [47:0] mac);
      to_wait(tag, mac);
      i_ctrl_resp_valid = 1'b1;
      i_ctrl_resp_data  = resp_of(mac);
      step();
      i_ctrl_resp_valid = 1'b0;
      check({tag, "_wr_valid"}, EW'(wr_valid), EW'(1));
      check({tag, "_wr_data"}, wr_data, resp_of(mac));
      step();
      check({tag, "_wr_valid_drop"}, EW'(wr_valid), EW'(0));
   endtask

   initial begin
      int wr_seen;
      rst = 1'b1;
      miss_valid = 1'b0;
      miss_dest_mac = '0; miss_src_mac = '0; miss_dest_ip = '0; miss_src_ip = '0; miss_ifc = '0;
      i_ctrl_req_ready = 1'b0;
      i_ctrl_resp_valid = 1'b0;
      i_ctrl_resp_data = '0;
      step();
      step();
      check("rst_req_valid", EW'(o_ctrl_req_valid), EW'(0));
      check("rst_wr_valid", EW'(wr_valid), EW'(0));
      check("rst_wr_data", wr_data, '0);
      check("rst_req_data", o_ctrl_req_data, '0);
      check("rst_busy", EW'(o_busy), EW'(0));
      check("rst_drop", EW'(o_drop_cnt), EW'(0));
      check("rst_tmo", EW'(o_timeout_cnt), EW'(0));
      rst = 1'b0;
      step();

      // Single round trip, ready tied high, reply two cycles after request
      i_ctrl_req_ready = 1'b1;
      send_miss(48'h0200_0000_0001);
      check("rt_busy_n1", EW'(o_busy), EW'(1));
      check("rt_req_n1", EW'(o_ctrl_req_valid), EW'(0));
      step();
      check("rt_req_valid_n2", EW'(o_ctrl_req_valid), EW'(1));
      check("rt_req_data_n2", o_ctrl_req_data, exp_req(48'h0200_0000_0001));
      step();
      check("rt_req_low_n3", EW'(o_ctrl_req_valid), EW'(0));
      step();
      i_ctrl_resp_valid = 1'b1;
      i_ctrl_resp_data  = resp_of(48'h0200_0000_0001);
      check("rt_wr_low_n4", EW'(wr_valid), EW'(0));
      step();
      i_ctrl_resp_valid = 1'b0;
      check("rt_wr_valid", EW'(wr_valid), EW'(1));
      check("rt_wr_data", wr_data, resp_of(48'h0200_0000_0001));
      step();
      check("rt_wr_one_cycle", EW'(wr_valid), EW'(0));
      check("rt_wr_data_hold", wr_data, resp_of(48'h0200_0000_0001));
      check("rt_busy_done", EW'(o_busy), EW'(0));
      i_ctrl_req_ready = 1'b0;

      // Overflow: 10 back-to-back misses, ready low
      for (int k = 0; k < 10; k++) begin
         set_miss(48'h0200_0000_0010 + 48'(k));
         step();
      end
      miss_valid = 1'b0;
      check("ovf_drop", EW'(o_drop_cnt), EW'(1));
      check("ovf_req_head", o_ctrl_req_data, exp_req(48'h0200_0000_0010));
      for (int k = 0; k < 9; k++)
         txn($sformatf("ovf%0d", k), 48'h0200_0000_0010 + 48'(k));
      check("ovf_drop_after", EW'(o_drop_cnt), EW'(1));
      check("ovf_busy_after", EW'(o_busy), EW'(0));

      // Timeout after 16 WAIT cycles with no reply
      send_miss(48'h0200_0000_0030);
      to_wait("tmo", 48'h0200_0000_0030);
      wr_seen = 0;
      for (int k = 0; k < 15; k++) begin
         if (wr_valid) wr_seen++;
         step();
      end
      check("tmo_busy_w16", EW'(o_busy), EW'(1));
      check("tmo_cnt_w16", EW'(o_timeout_cnt), EW'(0));
      step();
      check("tmo_cnt", EW'(o_timeout_cnt), EW'(1));
      check("tmo_idle", EW'(o_busy), EW'(0));
      check("tmo_no_write", EW'(wr_seen + int'(wr_valid)), EW'(0));

      // Stale reply then matching reply
      send_miss(48'h0200_0000_0040);
      to_wait("stale", 48'h0200_0000_0040);
      i_ctrl_resp_valid = 1'b1;
      i_ctrl_resp_data  = resp_of(48'h0200_0000_0041);
      step();
      i_ctrl_resp_valid = 1'b0;
      check("stale_no_wr", EW'(wr_valid), EW'(0));
      step();
      check("stale_no_wr2", EW'(wr_valid), EW'(0));
      i_ctrl_resp_valid = 1'b1;
      i_ctrl_resp_data  = resp_of(48'h0200_0000_0040);
      step();
      i_ctrl_resp_valid = 1'b0;
      check("stale_match_wr", EW'(wr_valid), EW'(1));
      check("stale_match_data", wr_data, resp_of(48'h0200_0000_0040));
      step();
      check("stale_wr_drop", EW'(wr_valid), EW'(0));

      // Same dest_mac three times
      for (int k = 0; k < 3; k++) begin
         set_miss(48'h0200_0000_0050);
         step();
      end
      miss_valid = 1'b0;
`ifdef FT_MISS_DEDUP_EN
      check("dup_drop", EW'(o_drop_cnt), EW'(3));
      txn("dup0", 48'h0200_0000_0050);
      step();
      step();
      check("dup_no_more_req", EW'(o_ctrl_req_valid), EW'(0));
      check("dup_busy", EW'(o_busy), EW'(0));
`else
      check("dup_drop", EW'(o_drop_cnt), EW'(1));
      txn("dup0", 48'h0200_0000_0050);
      txn("dup1", 48'h0200_0000_0050);
      txn("dup2", 48'h0200_0000_0050);
      check("dup_busy", EW'(o_busy), EW'(0));
`endif

      // Reset during WAIT with three misses queued
      for (int k = 0; k < 4; k++) begin
         set_miss(48'h0200_0000_0060 + 48'(k));
         step();
      end
      miss_valid = 1'b0;
      to_wait("rstw", 48'h0200_0000_0060);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rstw_req_valid", EW'(o_ctrl_req_valid), EW'(0));
      check("rstw_wr_valid", EW'(wr_valid), EW'(0));
      check("rstw_wr_data", wr_data, '0);
      check("rstw_req_data", o_ctrl_req_data, '0);
      check("rstw_busy", EW'(o_busy), EW'(0));
      check("rstw_drop", EW'(o_drop_cnt), EW'(0));
      check("rstw_tmo", EW'(o_timeout_cnt), EW'(0));
      i_ctrl_resp_valid = 1'b1;
      i_ctrl_resp_data  = resp_of(48'h0200_0000_0060);
      step();
      i_ctrl_resp_valid = 1'b0;
      check("rstw_no_wr", EW'(wr_valid), EW'(0));
      step();
      check("rstw_no_wr2", EW'(wr_valid), EW'(0));
      check("rstw_no_req", EW'(o_ctrl_req_valid), EW'(0));
      check("rstw_idle", EW'(o_busy), EW'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/ft_miss_handler.md
# ft_miss_handler

Buffers forwarding-table misses and serialises them to the SDN controller one at a time. Installs each controller reply into the forwarding table through its write interface. Sits directly downstream of `forwarding_table`'s miss interface and upstream of its `wr_valid`/`wr_data` port, bridging the table to the controller link.

## Interface
Parameters:
- `NUM_INTERFACES`, 3: number of switch ports; `IFW = $clog2(NUM_INTERFACES)`.
- `ENTRY_WIDTH`, 168: table entry / request width.
- `FIFO_DEPTH`, 8: miss queue depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in WAIT.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `miss_valid`  in  1: one-cycle miss pulse from the table; there is no ready.
- `miss_dest_mac`  in  48: dest MAC of the missed header.
- `miss_src_mac`  in  48: src MAC of the missed header.
- `miss_dest_ip`  in  32: dest IP of the missed header.
- `miss_src_ip`  in  32: src IP of the missed header.
- `miss_ifc`  in  IFW: ingress interface of the missed header.
- `o_ctrl_req_valid`  out  1: request to the controller is valid.
- `i_ctrl_req_ready`  in  1: controller accepts the request.
- `o_ctrl_req_data`  out  ENTRY_WIDTH: request contents, entry layout.
- `i_ctrl_resp_valid`  in  1: controller reply is valid.
- `i_ctrl_resp_data`  in  ENTRY_WIDTH: new table entry.
- `wr_valid`  out  1: table write strobe.
- `wr_data`  out  ENTRY_WIDTH: table write data.
- `o_busy`  out  1: FIFO non-empty or FSM not in IDLE.
- `o_drop_cnt`  out  16: saturating count of misses dropped.
- `o_timeout_cnt`  out  16: saturating count of WAIT timeouts.

## Operation
- Entry layout, MSB first:
  - [167:120] dest_mac
  - [119:72] src_mac
  - [71:40] dest_ip
  - [39:8] src_ip
  - [7:0] port, `miss_ifc` zero-extended in requests.
- Miss FIFO:
  - On `miss_valid`, push the packed request if the FIFO is not full.
  - Otherwise drop the miss and increment `o_drop_cnt`.
  - A push while full is dropped even if a pop occurs in the same cycle.
- FSM states IDLE, REQ, WAIT, WRITE:
  - IDLE: if the FIFO is non-empty, pop its head into the in-flight register and go to REQ.
  - REQ: `o_ctrl_req_valid=1` and `o_ctrl_req_data` = in-flight register, held stable. On `i_ctrl_req_ready`, go to WAIT and clear the timeout counter.
  - WAIT: the timeout counter increments each cycle.
    - If `i_ctrl_resp_valid` and resp[167:120] equals in-flight dest_mac: latch the response and go to WRITE.
    - A mismatching response is ignored as stale.
    - If the counter reaches `TIMEOUT_CYCLES-1` without a match: go to IDLE, increment `o_timeout_cnt`, discard the request.
    - A matching response in the timeout cycle wins.
  - WRITE: `wr_valid=1` for exactly one cycle with `wr_data` = latched response, then go to IDLE.
- `i_ctrl_resp_valid` outside WAIT is ignored.
- Counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - `o_ctrl_req_valid=0`, `wr_valid=0`, `wr_data=0`, `o_ctrl_req_data=0`
  - `o_busy=0`, both counters 0
  - FIFO empty, FSM IDLE.
- Reset mid-operation discards the in-flight request and all queued misses.
- Latency:
  - Miss at cycle N is in the FIFO at N+1.
  - If the FSM is idle, the pop occurs at N+1 and `o_ctrl_req_valid` rises at N+2.
- Response matched at cycle M gives `wr_valid` at M+1.
- Minimum round trip, miss to `wr_valid`, with immediate ready and response: 4 cycles.
- Back-to-back requests are separated by at least one IDLE cycle.
- `wr_data` holds its value after `wr_valid` drops.

## Configuration
- `FT_MISS_DEDUP_EN`
  - Defined: an incoming miss is dropped if its dest_mac equals any valid FIFO entry, or the in-flight request while in REQ/WAIT/WRITE. Each such drop increments `o_drop_cnt`.
  - Undefined: no comparison; every miss is queued subject only to capacity.

## Test plan
- Single round trip: miss dest_mac 02:00:00:00:00:01 with ready tied high; reply with a matching entry two cycles after the request → `wr_valid` one cycle with `wr_data` equal to the reply; `o_busy` returns to 0.
- Overflow: hold `i_ctrl_req_ready=0` and send 10 misses with distinct MACs.
  - `o_drop_cnt=1` (one in flight, 8 queued).
  - Release, then answer all 9 → 9 writes in order.
- Timeout with `TIMEOUT_CYCLES=16` and no response: FSM returns to IDLE after 16 WAIT cycles; `o_timeout_cnt=1`; no `wr_valid`.
- Stale response in WAIT with the wrong dest_mac → no write; a later matching response → one write.
- With `FT_MISS_DEDUP_EN`: send the same dest_mac 3 times → one controller request, `o_drop_cnt=2`. Without the macro → three requests.
- Assert `rst` during WAIT with 3 misses queued → next cycle all outputs at reset values; a subsequent response produces no write.
